// File: rtl/pipeline_step_ctrl.sv
// Run/step/breakpoint controller: debounces the step button and sequences the core's global enable.
// Optional PC breakpoint halt is compiled in when PIPE_STEP_BREAKPOINT_EN is defined.
module pipeline_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_CYCLES     = 1,
  parameter int CNT_W           = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_btn_step,
  input  logic             i_run_mode,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_bp_addr,
  input  logic             i_bp_valid,
  output logic             o_pipe_en,
  output logic             o_halted,
  output logic             o_bp_hit,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int STEP_W = $clog2(STEP_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEP_CYCLES);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [STEP_W-1:0]  step_cnt, step_cnt_n;
  logic               sync1, sync2;
  logic               btn_db, btn_db_d;
  logic [DB_W-1:0]    db_cnt;
  logic               press;
  logic [CNT_W-1:0]   cycle_cnt;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= i_btn_step;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_db_d <= btn_db;
      if (sync2 != btn_db) begin
        if (db_cnt == DB_LAST) begin
          btn_db <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = btn_db & ~btn_db_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state    <= ST_HALT;
      step_cnt <= '0;
    end else begin
      state    <= state_n;
      step_cnt <= step_cnt_n;
    end
  end

`ifdef PIPE_STEP_BREAKPOINT_EN
  logic bp_match;
  assign bp_match = i_bp_valid && (i_pc == i_bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{i_pc, i_bp_addr, i_bp_valid};
`endif

  always_comb begin
    state_n    = state;
    step_cnt_n = step_cnt;
    case (state)
      ST_HALT: begin
        if (i_run_mode) begin
          state_n = ST_RUN;
        end else if (press) begin
          state_n    = ST_STEP;
          step_cnt_n = STEP_LOAD;
        end
      end
      // Presses and run-switch changes are ignored until the step burst completes.
      ST_STEP: begin
        step_cnt_n = step_cnt - STEP_ONE;
        if (step_cnt <= STEP_ONE) begin
          state_n = ST_HALT;
        end
      end
      ST_RUN: begin
`ifdef PIPE_STEP_BREAKPOINT_EN
        if (bp_match) begin
          state_n = ST_BREAK;
        end else if (!i_run_mode) begin
          state_n = ST_HALT;
        end
`else
        if (!i_run_mode) begin
          state_n = ST_HALT;
        end
`endif
      end
`ifdef PIPE_STEP_BREAKPOINT_EN
      ST_BREAK: begin
        if (press) begin
          state_n    = ST_STEP;
          step_cnt_n = STEP_LOAD;
        end else if (!i_run_mode) begin
          state_n = ST_HALT;
        end
      end
`endif
      default: begin
        state_n = ST_HALT;
      end
    endcase
  end

  assign o_pipe_en = (state == ST_RUN) || (state == ST_STEP);
`ifdef PIPE_STEP_BREAKPOINT_EN
  assign o_halted  = (state == ST_HALT) || (state == ST_BREAK);
  assign o_bp_hit  = (state == ST_BREAK);
`else
  assign o_halted  = (state == ST_HALT);
  assign o_bp_hit  = 1'b0;
`endif

  // Free-running enabled-cycle counter; wraps silently.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cycle_cnt <= '0;
    end else if (o_pipe_en) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  assign o_cycle_cnt = cycle_cnt;

endmodule
